// File: rtl/inst_queue_if.sv
// Fetch/issue bundle for inst_queue: the master drives push/pop/select,
// the slave (the queue) returns the selected instruction, status and decoded fields.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            push;
  logic [31:0]     push_inst;
  logic            pop;
  logic            sel_inst;
  logic            issue_valid;
  logic [31:0]     issue_inst;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;
  logic [5:0]      opcode_head;
  logic [4:0]      rs_next_q;
  logic [4:0]      rt_next_q;
  logic [4:0]      rd1_q;
  logic [4:0]      rd2_q;
  logic [2:0]      read;
  logic            overflow_err;

  modport master (
    output push, push_inst, pop, sel_inst,
    input  issue_valid, issue_inst, full, empty, count, opcode_head,
           rs_next_q, rt_next_q, rd1_q, rd2_q, read, overflow_err
  );

  modport slave (
    input  push, push_inst, pop, sel_inst,
    output issue_valid, issue_inst, full, empty, count, opcode_head,
           rs_next_q, rt_next_q, rd1_q, rd2_q, read, overflow_err
  );
endinterface

// File: rtl/inst_queue.sv
// Shift-organised instruction queue: entry0 is oldest, the scheduler may issue entry1
// ahead of entry0 (swap pop). Field outputs are zero-latency decodes of the head entries.
module inst_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  inst_queue_if.slave  q
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] TwoC   = CntW'(2);

  logic [31:0]     entries_q [DEPTH];
  logic [31:0]     entries_d [DEPTH];
  logic [CntW-1:0] count_q, count_d;
  logic [2:0]      read_q, read_d;
  logic            overflow_q, overflow_d;

  logic            pop_ok, swap, push_ok;
  logic [CntW-1:0] wr_idx;
  logic [CntW-1:0] cnt_vis;
  logic            has0, has1;

  // R-type (opcode 0) writes rd, everything else writes rt.
  function automatic logic [4:0] dest_of(input logic [31:0] inst);
    return (inst[31:26] == 6'b000000) ? inst[15:11] : inst[20:16];
  endfunction

  always_comb begin
    pop_ok  = q.pop && (count_q != '0);
    swap    = pop_ok && q.sel_inst && (count_q >= TwoC);
    push_ok = q.push && ((count_q < DepthC) || pop_ok);
    wr_idx  = count_q - CntW'(pop_ok);

    entries_d = entries_q;
    if (pop_ok) begin
      // A swap pop keeps entry0 and closes the gap left by entry1.
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (!swap || i >= 1) entries_d[i] = entries_q[i+1];
      end
      entries_d[DEPTH-1] = '0;
    end
    if (push_ok) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CntW'(i) == wr_idx) entries_d[i] = q.push_inst;
      end
    end

    count_d    = count_q + CntW'(push_ok) - CntW'(pop_ok);
    read_d     = read_q + 3'(pop_ok);
    overflow_d = overflow_q | (q.push & ~push_ok);

    if (reset) begin
      entries_d  = '{default: '0};
      count_d    = '0;
      read_d     = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    entries_q  <= entries_d;
    count_q    <= count_d;
    read_q     <= read_d;
    overflow_q <= overflow_d;
  end

  always_comb begin
    // Status and fields read as empty while reset is held.
    cnt_vis = reset ? '0 : count_q;
    has0    = (cnt_vis != '0);
    has1    = (cnt_vis >= TwoC);

    q.count        = cnt_vis;
    q.empty        = !has0;
    q.full         = (cnt_vis == DepthC);
    q.issue_valid  = has0;
    q.read         = read_q;
    q.overflow_err = overflow_q;

    q.issue_inst   = '0;
    if (has0) q.issue_inst = (q.sel_inst && has1) ? entries_q[1] : entries_q[0];

    q.opcode_head = has0 ? entries_q[0][31:26] : '0;
    q.rd1_q       = has0 ? dest_of(entries_q[0]) : '0;
    q.rs_next_q   = has1 ? entries_q[1][25:21] : '0;
    q.rt_next_q   = has1 ? entries_q[1][20:16] : '0;
    q.rd2_q       = has1 ? dest_of(entries_q[1]) : '0;
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4): fill, swap pop, overflow, concurrent
// push/pop, empty edge cases and mid-operation reset, with hand-computed expectations.
module tb_inst_queue;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  inst_queue_if #(.DEPTH(4)) qif ();

  inst_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic [31:0] w, input logic pp, input logic sel);
    qif.push      = ps;
    qif.push_inst = w;
    qif.pop       = pp;
    qif.sel_inst  = sel;
  endtask

  // Peek entry0/entry1 through the combinational issue mux without popping.
  task automatic peek(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 check({tag, "_e0"}, qif.issue_inst, e0);
    qif.sel_inst = 1'b1;
    #1 check({tag, "_e1"}, qif.issue_inst, e1);
    qif.sel_inst = 1'b0;
    #1;
  endtask

  localparam logic [31:0] InstA = 32'h8C22_0004;
  localparam logic [31:0] InstB = 32'h0043_1820;
  localparam logic [31:0] InstC = 32'h00A6_3820;
  localparam logic [31:0] Beef  = 32'hDEAD_BEEF;

  logic [31:0] words [5];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    words[0] = 32'h2011_1111;
    words[1] = 32'h2422_2222;
    words[2] = 32'h2833_3333;
    words[3] = 32'h2C44_4444;
    words[4] = 32'h3055_5555;

    // Reset with a push pending: the word must be discarded.
    reset = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_empty", 32'(qif.empty), 32'd1);
    check("rst_full", 32'(qif.full), 32'd0);
    check("rst_valid", 32'(qif.issue_valid), 32'd0);
    check("rst_issue", qif.issue_inst, 32'd0);
    check("rst_read", 32'(qif.read), 32'd0);
    check("rst_ovf", 32'(qif.overflow_err), 32'd0);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 check("post_rst_count", 32'(qif.count), 32'd0);

    // Fill
    drive(1'b1, InstA, 1'b0, 1'b0); tick();
    drive(1'b1, InstB, 1'b0, 1'b0); tick();
    drive(1'b1, InstC, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("fill_count", 32'(qif.count), 32'd3);
    check("fill_opcode", 32'(qif.opcode_head), 32'h23);
    check("fill_rd1", 32'(qif.rd1_q), 32'd2);
    check("fill_rd2", 32'(qif.rd2_q), 32'd3);
    check("fill_rs_next", 32'(qif.rs_next_q), 32'd2);
    check("fill_rt_next", 32'(qif.rt_next_q), 32'd3);
    check("fill_valid", 32'(qif.issue_valid), 32'd1);

    // Swap pop issues entry1 and keeps entry0
    drive(1'b0, '0, 1'b1, 1'b1); #1;
    check("swap_issue", qif.issue_inst, InstB);
    tick();
    peek("swap", InstA, InstC);
    check("swap_count", 32'(qif.count), 32'd2);
    check("swap_read", 32'(qif.read), 32'd1);
    check("swap_rd2", 32'(qif.rd2_q), 32'd7);
    check("swap_rs_next", 32'(qif.rs_next_q), 32'd5);
    check("swap_rt_next", 32'(qif.rt_next_q), 32'd6);

    // Full / overflow
    reset = 1'b1; drive(1'b0, '0, 1'b0, 1'b0); tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      tick();
      if (i == 3) begin
        check("full_after4", 32'(qif.full), 32'd1);
        check("ovf_before5", 32'(qif.overflow_err), 32'd0);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("full_count", 32'(qif.count), 32'd4);
    check("full_ovf", 32'(qif.overflow_err), 32'd1);
    peek("full", words[0], words[1]);

    // Concurrent push+pop while full
    drive(1'b1, Beef, 1'b1, 1'b0); #1;
    check("conc_issue", qif.issue_inst, words[0]);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("conc_count", 32'(qif.count), 32'd4);
    check("conc_full", 32'(qif.full), 32'd1);
    peek("conc", words[1], words[2]);

    // Drain in order; last one out is the concurrent word at entry3
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_w;
      exp_w = (i == 3) ? Beef : words[i+1];
      drive(1'b0, '0, 1'b1, 1'b0); #1;
      check($sformatf("drain%0d", i), qif.issue_inst, exp_w);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("drain_empty", 32'(qif.empty), 32'd1);
    check("drain_read", 32'(qif.read), 32'd5);
    check("drain_issue", qif.issue_inst, 32'd0);

    // Pop while empty is ignored
    drive(1'b0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("epop_read", 32'(qif.read), 32'd5);
    check("epop_count", 32'(qif.count), 32'd0);

    // Push+pop on empty: only the push lands
    drive(1'b1, InstC, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("pp_empty_count", 32'(qif.count), 32'd1);
    check("pp_empty_read", 32'(qif.read), 32'd5);
    check("pp_empty_rs_next", 32'(qif.rs_next_q), 32'd0);

    // sel_inst with count==1 issues entry0
    drive(1'b0, '0, 1'b1, 1'b1); #1;
    check("sel1_issue", qif.issue_inst, InstC);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("sel1_count", 32'(qif.count), 32'd0);
    check("sel1_read", 32'(qif.read), 32'd6);

    // Mid-operation reset with push and pop active
    drive(1'b1, InstA, 1'b0, 1'b0); tick();
    drive(1'b1, InstB, 1'b0, 1'b0); tick();
    drive(1'b1, InstC, 1'b0, 1'b0); tick();
    drive(1'b1, Beef, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("mrst_during_empty", 32'(qif.empty), 32'd1);
    check("mrst_during_issue", qif.issue_inst, 32'd0);
    check("mrst_during_rd1", 32'(qif.rd1_q), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0); #1;
    check("mrst_count", 32'(qif.count), 32'd0);
    check("mrst_read", 32'(qif.read), 32'd0);
    check("mrst_ovf", 32'(qif.overflow_err), 32'd0);
    check("mrst_empty", 32'(qif.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
